mbus_wakeup_int_req_ctrl: RTL

- Layer-side requester upstream of the MBus member controller.
- Collects per-source interrupt requests from layer logic and drives the member controller's WAKEUP_REQ input, which wakes the MBus power domain.
- Once MBC_ISOLATE deasserts, presents one request at a time to the MBus layer controller through a valid/ack handshake.
- Runs on the always-on layer clock; adds timeout/retry on wakeup and a sticky error flag.

---
 rtl/mbus_wakeup_int_req_ctrl_if.sv | 27 ++
 rtl/mbus_wakeup_int_req_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mbus_wakeup_int_req_ctrl_if.sv
// rtl/mbus_wakeup_int_req_ctrl_if.sv - request/wakeup/grant bundle between layer logic, MBus controllers and the requester
interface mbus_wakeup_int_req_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] req_set;
  logic [NUM_SRC-1:0] req_mask;
  logic               mbc_isolate;
  logic               wakeup_req;
  logic               int_valid;
  logic [ID_W-1:0]    int_id;
  logic               int_ack;
  logic [NUM_SRC-1:0] pending;
  logic               timeout_err;
  logic               err_clr;
  logic               busy;

  modport master (
    input  req_set, req_mask, mbc_isolate, int_ack, err_clr,
    output wakeup_req, int_valid, int_id, pending, timeout_err, busy
  );

  modport slave (
    output req_set, req_mask, mbc_isolate, int_ack, err_clr,
    input  wakeup_req, int_valid, int_id, pending, timeout_err, busy
  );
endinterface

// File: rtl/mbus_wakeup_int_req_ctrl.sv
// rtl/mbus_wakeup_int_req_ctrl.sv - wakes the MBus domain and presents pending interrupt requests one at a time
module mbus_wakeup_int_req_ctrl #(
  parameter int NUM_SRC   = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 255,
  parameter int GAP_CYC   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mbus_wakeup_int_req_ctrl_if.master  bus
);
  localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, WAKE, GAP, GRANT} state_t;

  state_t             state;
  logic               iso_meta, iso_s;
  logic [NUM_SRC-1:0] pend, elig, clr;
  logic [CNT_W-1:0]   cnt;
  logic [RTY_W-1:0]   retry;
  logic [ID_W-1:0]    winner, int_id;
  logic               wakeup_req, int_valid, busy, timeout_err;

  // Isolate comes from another power domain; flops park at "asleep".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iso_meta <= 1'b1;
      iso_s    <= 1'b1;
    end else begin
      iso_meta <= bus.mbc_isolate;
      iso_s    <= iso_meta;
    end
  end

  assign elig = pend & bus.req_mask;
  assign clr  = (state == GRANT && bus.int_ack) ? (NUM_SRC'(1) << int_id) : '0;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // A new request on the bit being acknowledged survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~clr) | bus.req_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      retry       <= '0;
      int_id      <= '0;
      wakeup_req  <= 1'b0;
      int_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (bus.err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (elig != '0) begin
            if (!iso_s) begin
              state     <= GRANT;
              int_valid <= 1'b1;
              busy      <= 1'b1;
              int_id    <= winner;
            end else if (!timeout_err) begin
              state      <= WAKE;
              wakeup_req <= 1'b1;
              busy       <= 1'b1;
              cnt        <= '0;
              retry      <= '0;
            end
          end
        end
        WAKE, GAP: begin
          if (elig == '0) begin
            state      <= IDLE;
            wakeup_req <= 1'b0;
            busy       <= 1'b0;
          end else if (!iso_s) begin
            state      <= GRANT;
            wakeup_req <= 1'b0;
            int_valid  <= 1'b1;
            int_id     <= winner;
          end else if (state == WAKE && cnt == WAKE_LAST) begin
            cnt        <= '0;
            wakeup_req <= 1'b0;
            if (retry < RTY_LAST) begin
              retry <= retry + 1'b1;
              state <= GAP;
            end else begin
              // Setting the error here outranks a same-cycle err_clr.
              timeout_err <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
            end
          end else if (state == GAP && cnt == GAP_LAST) begin
            cnt        <= '0;
            state      <= WAKE;
            wakeup_req <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GRANT: begin
          // Ack and bus-asleep both return to IDLE; only the ack clears pend.
          if (bus.int_ack || iso_s) begin
            state     <= IDLE;
            int_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          wakeup_req <= 1'b0;
          int_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wakeup_req  = wakeup_req;
  assign bus.int_valid   = int_valid;
  assign bus.int_id      = int_id;
  assign bus.pending     = pend;
  assign bus.timeout_err = timeout_err;
  assign bus.busy        = busy;
endmodule
